// File: rtl/scie_fir_pkg.sv
// -----------------------------------------------------------------------------
// scie_fir_pkg
// Shared definitions for the multi-channel SCIE FIR accelerator:
//   - custom-instruction opcodes and CFG funct3 sub-operations
//   - controller FSM state encoding
//   - per-channel output mode (wrap / saturate)
// -----------------------------------------------------------------------------
package scie_fir_pkg;

    // Custom-instruction major opcodes (insn[6:0])
    localparam logic [6:0] OP_CFG  = 7'h0B;
    localparam logic [6:0] OP_PUSH = 7'h2B;
    localparam logic [6:0] OP_READ = 7'h5B;

    // CFG sub-operations (insn[14:12])
    localparam logic [2:0] F3_COEF  = 3'd0;
    localparam logic [2:0] F3_CLEAR = 3'd1;
    localparam logic [2:0] F3_MODE  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/scie_fir_multi_if.sv
// -----------------------------------------------------------------------------
// scie_fir_multi_if
// Instruction/result handshake between the core (master) and the FIR
// accelerator (slave).
//   io_valid    : instruction offered            (master -> slave)
//   io_insn     : instruction word               (master -> slave)
//   io_rs1      : operand 1 (coef/sample/mode)   (master -> slave)
//   io_rs2      : operand 2 (tap index)          (master -> slave)
//   io_ready    : accelerator accepts this cycle (slave -> master)
//   io_rd       : read result                    (slave -> master)
//   io_rd_valid : io_rd updated this cycle       (slave -> master)
// -----------------------------------------------------------------------------
interface scie_fir_multi_if #(
    parameter int XLEN = 32
);
    logic            io_valid;
    logic [XLEN-1:0] io_insn;
    logic [XLEN-1:0] io_rs1;
    logic [XLEN-1:0] io_rs2;
    logic            io_ready;
    logic [XLEN-1:0] io_rd;
    logic            io_rd_valid;

    modport master (
        output io_valid, io_insn, io_rs1, io_rs2,
        input  io_ready, io_rd, io_rd_valid
    );

    modport slave (
        input  io_valid, io_insn, io_rs1, io_rs2,
        output io_ready, io_rd, io_rd_valid
    );
endinterface

// File: rtl/scie_fir_mac.sv
// -----------------------------------------------------------------------------
// scie_fir_mac
// Shared multiply-accumulate engine, one tap per enabled cycle, with a
// wrap/saturate conversion of the accumulator to XLEN bits.
//   clock, reset : clock and asynchronous active-high reset
//   clear_i      : zero the accumulator (start of a new filter run)
//   en_i         : accumulate x_i * coef_i this cycle
//   x_i, coef_i  : signed sample and coefficient of the current tap
//   mode_i       : output conversion of the channel being computed
//   result_o     : accumulator converted to XLEN bits
// -----------------------------------------------------------------------------
module scie_fir_mac
    import scie_fir_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  mode_e                    mode_i,
    output logic        [XLEN-1:0]   result_o
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     fits;

    assign prod = x_i * coef_i;

    always_comb begin
        // NOTE: default first so every path assigns acc_d; a missing else would infer a latch.
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignment for state so all flops update together at the edge.
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // The accumulator fits in XLEN signed bits when every bit above the
    // XLEN-1 sign position replicates it.
    assign fits = (&acc_q[ACC_W-1:XLEN-1]) | ~(|acc_q[ACC_W-1:XLEN-1]);

    always_comb begin
        result_o = acc_q[XLEN-1:0];
        if (mode_i == MODE_SAT && !fits) begin
            result_o = acc_q[ACC_W-1] ? {1'b1, {(XLEN-1){1'b0}}}
                                      : {1'b0, {(XLEN-1){1'b1}}};
        end
    end

endmodule

// File: rtl/scie_fir_multi.sv
// -----------------------------------------------------------------------------
// scie_fir_multi
// Multi-channel FIR custom-instruction accelerator. Each channel owns a
// coefficient bank, a sample delay line, an output mode and a result
// register; one shared MAC walks the taps of the pushed channel.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : instruction/result handshake (slave side)
// -----------------------------------------------------------------------------
module scie_fir_multi
    import scie_fir_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAPS     = 8,
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 40
) (
    input  logic            clock,
    input  logic            reset,
    scie_fir_multi_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IDX_W = $clog2(TAPS);

    // Per-channel storage
    logic signed [COEF_W-1:0] coef_q   [CHANNELS][TAPS];
    logic signed [DATA_W-1:0] x_q      [CHANNELS][TAPS];
    logic        [XLEN-1:0]   result_q [CHANNELS];
    mode_e                    mode_q   [CHANNELS];

    // Controller state
    state_e           state_q;
    logic             ready_q;
    logic [IDX_W-1:0] idx_q;
    logic [CH_W-1:0]  ch_q;
    logic [XLEN-1:0]  rd_q;
    logic             rd_valid_q;

    // Decode
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [CH_W-1:0]  ch;
    logic [IDX_W-1:0] tap;
    logic             ch_ok, tap_ok, accept, mac_clear;
    logic [XLEN-1:0]  mac_result;
    logic             unused_bits;

    assign opcode = bus.io_insn[6:0];
    assign funct3 = bus.io_insn[14:12];
    assign ch     = bus.io_insn[25 +: CH_W];
    assign tap    = bus.io_rs2[IDX_W-1:0];
    assign ch_ok  = (int'(ch) < CHANNELS);
    assign tap_ok = (bus.io_rs2 < XLEN'(TAPS));
    assign accept = bus.io_valid && ready_q;

    // Only a fraction of the instruction and operand bits carry meaning.
    assign unused_bits = ^{bus.io_insn, bus.io_rs1};

    // Accumulator restarts at the same edge the new sample enters the line.
    assign mac_clear = accept && (opcode == OP_PUSH) && ch_ok;

    scie_fir_mac #(
        .XLEN   (XLEN),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (mac_clear),
        .en_i     (state_q == ST_MAC),
        .x_i      (x_q[ch_q][idx_q]),
        .coef_i   (coef_q[ch_q][idx_q]),
        .mode_i   (mode_q[ch_q]),
        .result_o (mac_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            idx_q      <= '0;
            ch_q       <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            // NOTE: these arrays are architectural state that must read back as zero after reset, so they are flops with reset rather than RAM.
            for (int c = 0; c < CHANNELS; c++) begin
                result_q[c] <= '0;
                mode_q[c]   <= MODE_WRAP;
                for (int t = 0; t < TAPS; t++) begin
                    coef_q[c][t] <= '0;
                    x_q[c][t]    <= '0;
                end
            end
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_CFG: begin
                                if (ch_ok) begin
                                    case (funct3)
                                        F3_COEF: begin
                                            if (tap_ok) begin
                                                coef_q[ch][tap] <= bus.io_rs1[COEF_W-1:0];
                                            end
                                        end
                                        F3_CLEAR: begin
                                            result_q[ch] <= '0;
                                            for (int t = 0; t < TAPS; t++) begin
                                                x_q[ch][t] <= '0;
                                            end
                                        end
                                        F3_MODE: mode_q[ch] <= mode_e'(bus.io_rs1[0]);
                                        default: ;
                                    endcase
                                end
                            end
                            OP_PUSH: begin
                                if (ch_ok) begin
                                    // Index 0 is newest; the oldest sample falls off the end.
                                    x_q[ch][0] <= bus.io_rs1[DATA_W-1:0];
                                    for (int t = 1; t < TAPS; t++) begin
                                        x_q[ch][t] <= x_q[ch][t-1];
                                    end
                                    ch_q    <= ch;
                                    idx_q   <= '0;
                                    state_q <= ST_MAC;
                                    ready_q <= 1'b0;
                                end
                            end
                            OP_READ: begin
                                rd_q       <= ch_ok ? result_q[ch] : '0;
                                rd_valid_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MAC: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(TAPS - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_q[ch_q] <= mac_result;
                    state_q        <= ST_IDLE;
                    ready_q        <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.io_ready    = ready_q;
    assign bus.io_rd       = rd_q;
    assign bus.io_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_scie_fir_multi.sv
// -----------------------------------------------------------------------------
// tb_scie_fir_multi
// Directed self-checking bench for scie_fir_multi. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_scie_fir_multi;
    import scie_fir_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAPS  = 8;
    localparam int BOUND = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    scie_fir_multi_if #(.XLEN(XLEN)) bus();

    scie_fir_multi #(
        .XLEN     (XLEN),
        .TAPS     (TAPS),
        .CHANNELS (4),
        .DATA_W   (16),
        .COEF_W   (16),
        .ACC_W    (40)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input int ch);
        return (32'(ch) << 25) | (32'(f3) << 12) | 32'(op);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction, wait (bounded) until it is accepted, then drop valid.
    task automatic send(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        int n;
        @(negedge clock);
        bus.io_valid = 1'b1;
        bus.io_insn  = insn;
        bus.io_rs1   = rs1;
        bus.io_rs2   = rs2;
        n = 0;
        while (bus.io_ready !== 1'b1 && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        if (n >= BOUND) check("ready_timeout", 64'(bus.io_ready), 64'd1);
        @(negedge clock);
        bus.io_valid = 1'b0;
    endtask

    task automatic coef(input int ch, input int tap, input int val);
        send(mk(OP_CFG, F3_COEF, ch), 32'(val), 32'(tap));
    endtask

    task automatic push(input int ch, input int val);
        send(mk(OP_PUSH, 3'd0, ch), 32'(val), 32'd0);
    endtask

    task automatic read_chk(input string tag, input int ch, input logic [31:0] exp);
        send(mk(OP_READ, 3'd0, ch), 32'd0, 32'd0);
        check(tag, 64'(bus.io_rd), 64'(exp));
        check({tag, "_v"}, 64'(bus.io_rd_valid), 64'd1);
    endtask

    initial begin
        int cnt;
        bus.io_valid = 1'b0;
        bus.io_insn  = '0;
        bus.io_rs1   = '0;
        bus.io_rs2   = '0;

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 64'(bus.io_ready), 64'd1);
        check("rst_rd", 64'(bus.io_rd), 64'd0);
        check("rst_rd_valid", 64'(bus.io_rd_valid), 64'd0);
        read_chk("rst_read_ch0", 0, 32'd0);

        // Coefficients: ch0 = 33,32,57,47,94; ch1 tap0 = 2
        coef(0, 0, 33); coef(0, 1, 32); coef(0, 2, 57); coef(0, 3, 47); coef(0, 4, 94);
        coef(1, 0, 2);

        // Main filter sequence with a ch1 push interleaved
        push(0, 50); read_chk("ch0_p1", 0, 32'd1650);
        push(1, 7);  read_chk("ch1_p1", 1, 32'd14);
        push(0, 92); read_chk("ch0_p2", 0, 32'd4636);
        push(0, 58); read_chk("ch0_p3", 0, 32'd7708);
        push(0, 64); read_chk("ch0_p4", 0, 32'd11562);

        // Handshake: READ held right after the PUSH
        push(0, 40);
        bus.io_valid = 1'b1;
        bus.io_insn  = mk(OP_READ, 3'd0, 0);
        cnt = 0;
        while (bus.io_ready !== 1'b1 && cnt < BOUND) begin
            cnt++;
            @(negedge clock);
        end
        check("hs_busy_cycles", 64'(cnt), 64'(TAPS + 1));
        @(negedge clock);
        bus.io_valid = 1'b0;
        check("hs_rd", 64'(bus.io_rd), 64'd15698);
        check("hs_rd_valid", 64'(bus.io_rd_valid), 64'd1);
        @(negedge clock);
        check("hs_rd_valid_pulse", 64'(bus.io_rd_valid), 64'd0);
        check("hs_rd_hold", 64'(bus.io_rd), 64'd15698);

        // Channel isolation, plus ignored funct3 and unknown opcode
        send(mk(OP_CFG, 3'd5, 1), 32'd99, 32'd0);
        send(mk(7'h7B, 3'd0, 1), 32'd99, 32'd0);
        read_chk("ch1_isolated", 1, 32'd14);

        // Clear ch0
        send(mk(OP_CFG, F3_CLEAR, 0), 32'd0, 32'd0);
        read_chk("ch0_clear", 0, 32'd0);
        push(0, 10); read_chk("ch0_after_clear", 0, 32'd330);

        // Out-of-range tap index is ignored: 1*33 + 10*32
        coef(0, 8, 1000);
        push(0, 1); read_chk("ch0_tap_oob", 0, 32'd353);

        // Positive saturation on ch2
        send(mk(OP_CFG, F3_MODE, 2), 32'd1, 32'd0);
        for (int t = 0; t < TAPS; t++) coef(2, t, 32767);
        push(2, 32767); read_chk("ch2_sat_one", 2, 32'h3FFF0001);
        for (int i = 1; i < TAPS; i++) push(2, 32767);
        read_chk("ch2_sat_pos", 2, 32'h7FFFFFFF);

        // Same run in wrap mode
        send(mk(OP_CFG, F3_CLEAR, 2), 32'd0, 32'd0);
        send(mk(OP_CFG, F3_MODE, 2), 32'd0, 32'd0);
        for (int i = 0; i < TAPS; i++) push(2, 32767);
        read_chk("ch2_wrap", 2, 32'hFFF80008);

        // Negative saturation on ch3
        send(mk(OP_CFG, F3_MODE, 3), 32'd1, 32'd0);
        for (int t = 0; t < TAPS; t++) coef(3, t, -32768);
        for (int i = 0; i < TAPS; i++) push(3, 32767);
        read_chk("ch3_sat_neg", 3, 32'h80000000);

        // Reset in the middle of a MAC run
        push(0, 3);
        @(negedge clock);
        check("mid_mac_busy", 64'(bus.io_ready), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mr_ready", 64'(bus.io_ready), 64'd1);
        check("mr_rd", 64'(bus.io_rd), 64'd0);
        check("mr_rd_valid", 64'(bus.io_rd_valid), 64'd0);
        read_chk("mr_ch0", 0, 32'd0);
        read_chk("mr_ch2", 2, 32'd0);
        push(0, 5); read_chk("mr_coef_zero", 0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scie_fir_multi.md
Name: scie_fir_multi

Overview:
- Next-generation SCIE custom-instruction FIR accelerator for the rocket core.
- Holds CHANNELS independent FIR filters, each with its own coefficient bank, sample delay line, output-mode setting and result register.
- MAC datapath is time-multiplexed: one tap per cycle. An io_ready handshake replaces the fixed-latency behaviour of the single-channel pipelined block.
- Adds per-channel clear and selectable wrap/saturate output.

Parameters:
- XLEN, 32, width of io_rs1/io_rs2/io_rd/io_insn.
- TAPS, 8, taps per channel (>=2).
- CHANNELS, 4, number of independent filters (power of two, <=8).
- DATA_W, 16, signed sample width, taken from rs1[DATA_W-1:0].
- COEF_W, 16, signed coefficient width, taken from rs1[COEF_W-1:0].
- ACC_W, 40, accumulator width (>= DATA_W+COEF_W+clog2(TAPS)).

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- io_valid  in  1  instruction offered
- io_insn  in  XLEN  instruction word
- io_rs1  in  XLEN  operand 1 (coef/sample/mode)
- io_rs2  in  XLEN  operand 2 (tap index)
- io_ready  out  1  block accepts an instruction this cycle
- io_rd  out  XLEN  read result
- io_rd_valid  out  1  io_rd updated by a read this cycle (1-cycle pulse)

Behaviour:
- Decode fields:
  - opcode = insn[6:0]
  - funct3 = insn[14:12]
  - channel = insn[25 +: clog2(CHANNELS)]
- Accept condition: io_valid && io_ready. Instructions offered while io_ready=0 have no side effect; the requester holds them.
- opcode 0x0B (CFG):
  - funct3=0: coef[ch][rs2] <= rs1. Ignored if rs2 >= TAPS.
  - funct3=1: clear delay line and result of ch.
  - funct3=2: mode[ch] <= rs1[0] (0 = wrap, 1 = saturate).
  - Other funct3 values are ignored.
- opcode 0x2B (PUSH): shift rs1 sample into delay line ch (index 0 = newest), then start MAC.
- opcode 0x5B (READ): next cycle io_rd <= result[ch], io_rd_valid=1. io_rd holds its value until the next READ.
- Unknown opcodes are accepted and ignored.
- FSM:
  - IDLE: io_ready=1. PUSH -> MAC, with acc=0, idx=0.
  - MAC: io_ready=0. Each cycle acc += sext(x[ch][idx]) * sext(coef[ch][idx]), idx++. After idx=TAPS-1 -> DONE.
  - DONE: io_ready=0. result[ch] <= acc converted per mode -> IDLE.
  - Result available to a READ accepted TAPS+1 cycles after the PUSH was accepted.
- Arithmetic:
  - Full-precision signed products, summed in ACC_W bits.
  - Wrap: result = acc[XLEN-1:0].
  - Saturate: clamp acc to [-2^(XLEN-1), 2^(XLEN-1)-1].
- Reset (asynchronous, any state, including mid-MAC):
  - FSM -> IDLE.
  - All coefs, delay lines and results = 0; mode = wrap.
  - io_rd=0, io_rd_valid=0, io_ready=1 after reset deasserts.
- Boundary conditions:
  - Channel field >= CHANNELS: instruction ignored; a READ returns 0 with io_rd_valid=1.
  - A CFG to any channel during MAC is impossible, because io_ready=0.
  - Delay line drops its oldest sample on each push.

Decomposition:
- Package scie_fir_pkg: opcode constants (0x0B, 0x2B, 0x5B), funct3 codes, FSM state enum, mode enum.
- Sub-module scie_fir_mac: the ACC_W accumulator with a clear input and a wrap/saturate output stage, instantiated once.
- Top level owns decode, FSM, coefficient/delay-line register arrays and the channel mux.

Test Plan:
- Ch0 coefs 33,32,57,47,94 at taps 0-4 (rest 0); push 50,92,58,64,40, each followed by a READ once io_ready=1 -> io_rd = 1650, 4636, 7708, 11562, 15698.
- Channel isolation: ch1 coef tap0=2; push 7 to ch1 between the ch0 pushes above -> ch1 reads 14; ch0 sequence unchanged.
- Handshake: hold a READ with io_valid=1 right after a PUSH -> io_ready=0 for TAPS+1 cycles, then the READ is accepted and io_rd_valid pulses once with the new result.
- Saturate: ch2 mode=1, coef tap0=32767, push 32767 on every cycle io_ready allows, with a large coef on all taps so acc > 2^31-1 -> io_rd=0x7FFFFFFF; the same run in wrap mode -> acc[31:0].
- Clear: after the first test, CFG funct3=1 on ch0, then READ -> 0; push 10 -> 330.
- Reset mid-MAC: assert reset during MAC state -> io_ready=1 after release; READ ch0 -> 0; all coefs read back as 0 (push 5 -> 0).
